// File: rtl/bt656cap_pkg.sv
// Shared constants, stage types and helpers for the BT.656 capture YCbCr-to-RGB565 path.
// Holds the BT.601 coefficients and offsets so every consumer uses one definition.
package bt656cap_pkg;

  localparam int unsigned IW = 20;

  localparam logic signed [IW-1:0] KCy   = 20'sd298;
  localparam logic signed [IW-1:0] KRv   = 20'sd409;
  localparam logic signed [IW-1:0] KGu   = 20'sd100;
  localparam logic signed [IW-1:0] KGv   = 20'sd208;
  localparam logic signed [IW-1:0] KBu   = 20'sd516;
  localparam logic signed [IW-1:0] Round = 20'sd128;

  localparam logic [7:0] YOfs = 8'd16;
  localparam logic [7:0] COfs = 8'd128;

  typedef struct packed {
    logic              field;
    logic signed [8:0] c0;
    logic signed [8:0] c1;
    logic signed [8:0] d;
    logic signed [8:0] e;
  } s1_t;

  // Arithmetic shift by 8, then saturate to 0..255.
  function automatic logic [7:0] clamp8(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] s;
    s = v >>> 8;
    if (s[IW-1]) begin
      return 8'h00;
    end else if (|s[IW-2:8]) begin
      return 8'hff;
    end else begin
      return s[7:0];
    end
  endfunction

  function automatic logic [15:0] pack565(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/bt656cap_ycc2rgb_pix.sv
// One pixel's product stage (S2) and sum/round/clamp/pack stage (S3).
// Chroma terms D and E arrive from the top, shared by both pixels of a macropixel.
module bt656cap_ycc2rgb_pix
  import bt656cap_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ld2,
  input  logic              i_ld3,
  input  logic signed [8:0] i_c,
  input  logic signed [8:0] i_d,
  input  logic signed [8:0] i_e,
  output logic [15:0]       o_rgb
);

  logic signed [IW-1:0] w_c;
  logic signed [IW-1:0] w_d;
  logic signed [IW-1:0] w_e;
  logic signed [IW-1:0] w_sum_r;
  logic signed [IW-1:0] w_sum_g;
  logic signed [IW-1:0] w_sum_b;

  logic signed [IW-1:0] r_py;
  logic signed [IW-1:0] r_prv;
  logic signed [IW-1:0] r_pgu;
  logic signed [IW-1:0] r_pgv;
  logic signed [IW-1:0] r_pbu;
  logic [15:0]          r_rgb;

  assign w_c = IW'(i_c);
  assign w_d = IW'(i_d);
  assign w_e = IW'(i_e);

  assign w_sum_r = r_py + r_prv + Round;
  assign w_sum_g = r_py - r_pgu - r_pgv + Round;
  assign w_sum_b = r_py + r_pbu + Round;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_py  <= '0;
      r_prv <= '0;
      r_pgu <= '0;
      r_pgv <= '0;
      r_pbu <= '0;
      r_rgb <= '0;
    end else begin
      if (i_ld2) begin
        r_py  <= KCy * w_c;
        r_prv <= KRv * w_e;
        r_pgu <= KGu * w_d;
        r_pgv <= KGv * w_e;
        r_pbu <= KBu * w_d;
      end
      if (i_ld3) begin
        r_rgb <= pack565(clamp8(w_sum_r), clamp8(w_sum_g), clamp8(w_sum_b));
      end
    end
  end

  assign o_rgb = r_rgb;

endmodule

// File: rtl/bt656cap_ycc2rgb.sv
// 3-stage YCbCr 4:2:2 macropixel to dual-RGB565 converter with stall-on-backpressure.
// Stage data only loads behind a valid bit, so outputs hold their last word across bubbles.
module bt656cap_ycc2rgb
  import bt656cap_pkg::*;
#(
  parameter logic pix0_high = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        in_stb,
  output logic        in_ack,
  input  logic        in_field,
  input  logic [31:0] in_ycc,
  output logic        out_stb,
  input  logic        out_ack,
  output logic        out_field,
  output logic [31:0] out_rgb565
);

  logic        w_en;
  logic        w_ld2;
  logic        w_ld3;
  s1_t         w_s1;
  logic [15:0] w_p0;
  logic [15:0] w_p1;

  logic r_v1;
  logic r_v2;
  logic r_v3;
  s1_t  r_s1;
  logic r_f2;
  logic r_f3;

  assign w_en  = ~r_v3 | out_ack;
  assign w_ld2 = w_en & r_v1;
  assign w_ld3 = w_en & r_v2;

  // Empty pipeline during reset, so advertise ready; the reset branch discards the word.
  assign in_ack = ~sys_rst | w_en;

  assign w_s1.field = in_field;
  assign w_s1.c0    = $signed({1'b0, in_ycc[23:16]}) - $signed({1'b0, YOfs});
  assign w_s1.c1    = $signed({1'b0, in_ycc[7:0]}) - $signed({1'b0, YOfs});
  assign w_s1.d     = $signed({1'b0, in_ycc[31:24]}) - $signed({1'b0, COfs});
  assign w_s1.e     = $signed({1'b0, in_ycc[15:8]}) - $signed({1'b0, COfs});

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_s1 <= '0;
      r_f2 <= 1'b0;
      r_f3 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= in_stb;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (in_stb) r_s1 <= w_s1;
      if (r_v1)   r_f2 <= r_s1.field;
      if (r_v2)   r_f3 <= r_f2;
    end
  end

  bt656cap_ycc2rgb_pix u_pix0 (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst),
    .i_ld2   (w_ld2),
    .i_ld3   (w_ld3),
    .i_c     (r_s1.c0),
    .i_d     (r_s1.d),
    .i_e     (r_s1.e),
    .o_rgb   (w_p0)
  );

  bt656cap_ycc2rgb_pix u_pix1 (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst),
    .i_ld2   (w_ld2),
    .i_ld3   (w_ld3),
    .i_c     (r_s1.c1),
    .i_d     (r_s1.d),
    .i_e     (r_s1.e),
    .o_rgb   (w_p1)
  );

  assign out_stb    = r_v3;
  assign out_field  = r_f3;
  assign out_rgb565 = pix0_high ? {w_p0, w_p1} : {w_p1, w_p0};

endmodule

// File: tb/tb_bt656cap_ycc2rgb.sv
// Directed bench for bt656cap_ycc2rgb: colour vectors, clamping, lane order, stall and reset.
// A second instance with pix0_high=0 shares the stimulus to check lane ordering.
module tb_bt656cap_ycc2rgb;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        in_stb = 1'b0;
  logic        in_field = 1'b0;
  logic [31:0] in_ycc = '0;
  logic        out_ack = 1'b0;

  logic        in_ack;
  logic        out_stb;
  logic        out_field;
  logic [31:0] out_rgb565;
  logic        lo_in_ack;
  logic        lo_stb;
  logic        lo_field;
  logic [31:0] lo_rgb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bt656cap_ycc2rgb u_dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .in_stb     (in_stb),
    .in_ack     (in_ack),
    .in_field   (in_field),
    .in_ycc     (in_ycc),
    .out_stb    (out_stb),
    .out_ack    (out_ack),
    .out_field  (out_field),
    .out_rgb565 (out_rgb565)
  );

  bt656cap_ycc2rgb #(.pix0_high(1'b0)) u_dut_lo (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .in_stb     (in_stb),
    .in_ack     (lo_in_ack),
    .in_field   (in_field),
    .in_ycc     (in_ycc),
    .out_stb    (lo_stb),
    .out_ack    (out_ack),
    .out_field  (lo_field),
    .out_rgb565 (lo_rgb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single macropixel through an empty pipeline with out_ack held high.
  task automatic run_one(input string tag, input logic [31:0] ycc, input logic fld,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    in_stb   = 1'b1;
    in_ycc   = ycc;
    in_field = fld;
    out_ack  = 1'b1;
    #1;
    check_eq({tag, "_in_ack"}, {31'd0, in_ack}, 32'd1);
    step();
    in_stb   = 1'b0;
    in_ycc   = 32'hdeadbeef;
    in_field = ~fld;
    lat = 1;
    while (!out_stb && lat < 10) begin
      step();
      lat++;
    end
    check_eq({tag, "_lat"}, lat, 32'd3);
    check_eq({tag, "_rgb"}, out_rgb565, exp_hi);
    check_eq({tag, "_fld"}, {31'd0, out_field}, {31'd0, fld});
    check_eq({tag, "_lo_stb"}, {31'd0, lo_stb}, 32'd1);
    check_eq({tag, "_lo_rgb"}, lo_rgb, exp_lo);
    check_eq({tag, "_lo_fld"}, {31'd0, lo_field}, {31'd0, fld});
    step();
    check_eq({tag, "_drain"}, {31'd0, out_stb}, 32'd0);
  endtask

  logic [31:0] bp_ycc [8];
  logic [31:0] bp_exp [8];

  initial begin
    int idx_in;
    int idx_out;
    int cnt;
    logic acc;

    bp_ycc[0] = 32'h801080eb; bp_exp[0] = 32'h0000ffff;
    bp_ycc[1] = 32'h80eb8010; bp_exp[1] = 32'hffff0000;
    bp_ycc[2] = 32'h80808051; bp_exp[2] = 32'h84104a69;
    bp_ycc[3] = 32'h80518080; bp_exp[3] = 32'h4a698410;
    bp_ycc[4] = 32'h80b48032; bp_exp[4] = 32'hbdf72945;
    bp_ycc[5] = 32'h803280b4; bp_exp[5] = 32'h2945bdf7;
    bp_ycc[6] = 32'h80808080; bp_exp[6] = 32'h84108410;
    bp_ycc[7] = 32'h80b480eb; bp_exp[7] = 32'hbdf7ffff;

    // Reset state
    step();
    step();
    check_eq("rst_out_stb", {31'd0, out_stb}, 32'd0);
    check_eq("rst_out_field", {31'd0, out_field}, 32'd0);
    check_eq("rst_out_rgb", out_rgb565, 32'd0);
    check_eq("rst_in_ack", {31'd0, in_ack}, 32'd1);
    sys_rst = 1'b1;
    step();

    // Colour vectors
    run_one("black", 32'h80108010, 1'b0, 32'h00000000, 32'h00000000);
    run_one("white", 32'h80eb80eb, 1'b0, 32'hffffffff, 32'hffffffff);
    run_one("red",   32'h5a51f051, 1'b1, 32'hf800f800, 32'hf800f800);
    run_one("sat",   32'hffffffff, 1'b0, 32'hfbfffbff, 32'hfbfffbff);
    run_one("neg",   32'h80008000, 1'b1, 32'h00000000, 32'h00000000);
    run_one("lane",  32'h80eb8010, 1'b0, 32'hffff0000, 32'h0000ffff);

    // Backpressure: 8 back-to-back words, consumer stalled for the first 5 cycles
    idx_in  = 0;
    idx_out = 0;
    for (int cyc = 0; cyc < 60 && idx_out < 8; cyc++) begin
      in_stb = (idx_in < 8);
      if (idx_in < 8) begin
        in_ycc   = bp_ycc[idx_in];
        in_field = idx_in[0];
      end else begin
        in_ycc   = 32'h12345678;
        in_field = 1'b1;
      end
      out_ack = (cyc >= 5);
      #1;
      if (cyc == 4) begin
        check_eq("bp_accepts", idx_in, 32'd3);
        check_eq("bp_in_ack_low", {31'd0, in_ack}, 32'd0);
      end
      if (cyc == 3 || cyc == 4) begin
        check_eq("bp_hold_stb", {31'd0, out_stb}, 32'd1);
        check_eq("bp_hold_rgb", out_rgb565, bp_exp[0]);
        check_eq("bp_hold_fld", {31'd0, out_field}, 32'd0);
      end
      acc = in_stb & in_ack;
      if (out_stb && out_ack) begin
        check_eq("bp_rgb", out_rgb565, bp_exp[idx_out]);
        check_eq("bp_fld", {31'd0, out_field}, {31'd0, idx_out[0]});
        idx_out++;
      end
      step();
      if (acc) idx_in++;
    end
    in_stb = 1'b0;
    check_eq("bp_count", idx_out, 32'd8);
    step();
    check_eq("bp_empty", {31'd0, out_stb}, 32'd0);

    // Reset mid-stream with 3 words in flight
    out_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_stb   = 1'b1;
      in_ycc   = 32'h80eb80eb;
      in_field = 1'b1;
      step();
    end
    check_eq("mid_full_stb", {31'd0, out_stb}, 32'd1);
    sys_rst = 1'b0;
    in_stb  = 1'b1;
    #1;
    check_eq("mid_rst_in_ack", {31'd0, in_ack}, 32'd1);
    check_eq("mid_rst_lo_in_ack", {31'd0, lo_in_ack}, 32'd1);
    step();
    sys_rst = 1'b1;
    in_stb  = 1'b0;
    check_eq("mid_stb", {31'd0, out_stb}, 32'd0);
    check_eq("mid_field", {31'd0, out_field}, 32'd0);
    check_eq("mid_rgb", out_rgb565, 32'd0);
    out_ack = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_stb) cnt++;
      step();
    end
    check_eq("mid_no_output", cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bt656cap_ycc2rgb.md
BT656CAP_YCC2RGB -- requirements
Module: bt656cap_ycc2rgb

Interface
REQ-001 SHALL have parameter pix0_high, default 1: 1 places the first pixel (Y0) in out_rgb565[31:16]; 0 places it in [15:0].
REQ-002 SHALL have port sys_clk, input, 1: single clock; all logic is rising-edge.
REQ-003 SHALL have port sys_rst, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port in_stb, input, 1: an input macropixel is valid.
REQ-005 SHALL have port in_ack, output, 1: the input macropixel is accepted this cycle.
REQ-006 SHALL have port in_field, input, 1: field bit of the input macropixel.
REQ-007 SHALL have port in_ycc, input, 32: {Cb[31:24], Y0[23:16], Cr[15:8], Y1[7:0]}, BT.601 4:2:2.
REQ-008 SHALL have port out_stb, output, 1: an output word is valid.
REQ-009 SHALL have port out_ack, input, 1: the consumer (DMA) accepts the output word.
REQ-010 SHALL have port out_field, output, 1: field bit travelling with the output word.
REQ-011 SHALL have port out_rgb565, output, 32: two RGB565 pixels.

Function
REQ-012 SHALL implement a 3-stage pipeline:
- S1: C0=Y0-16, C1=Y1-16, D=Cb-128, E=Cr-128, all signed.
- S2: products 298*C, 409*E, 100*D, 208*E, 516*D.
- S3: sums, rounding, clamp and pack.
REQ-013 SHALL compute, per pixel:
- R=(298C+409E+128)>>>8
- G=(298C-100D-208E+128)>>>8
- B=(298C+516D+128)>>>8
- Sums use at least 20-bit signed arithmetic; >>> is an arithmetic shift.
REQ-014 SHALL clamp each of R, G and B to 0..255 (negative results give 0, results above 255 give 255), then pack the pixel as {R[7:3], G[7:2], B[7:3]}.
REQ-015 SHALL share D and E between both pixels of a macropixel (no chroma interpolation).
REQ-016 SHALL carry a valid bit and the field bit with each stage.
REQ-017 SHALL drive out_stb, out_field and out_rgb565 directly from S3 registers.
REQ-018 SHALL have a latency of exactly 3 cycles from the in_stb&in_ack edge to out_stb when there is no stall.
REQ-019 SHALL define pipeline enable as en = ~S3.valid | out_ack, and drive in_ack = en (combinational).
REQ-020 SHALL hold every stage register and valid bit unchanged while en=0, so no data is lost or duplicated under backpressure.
REQ-021 SHALL, when en=1, load S1.valid with in_stb and let bubbles propagate.
REQ-022 SHALL sustain one word per cycle when in_stb=1 and out_ack=1 continuously.
REQ-023 SHALL accept a new input in the same cycle that a full pipeline drains (out_ack=1 with S3 valid).
REQ-024 SHALL keep out_rgb565 and out_field stable while out_stb=1 and out_ack=0.
REQ-025 SHALL ignore in_ycc and in_field when in_stb=0.
REQ-026 SHALL ignore out_ack when out_stb=0.

Reset
REQ-027 SHALL, when sys_rst=0 at a clock edge, clear all valid bits; out_stb=0, out_field=0 and out_rgb565=0 from that edge on.
REQ-028 SHALL drive in_ack=1 while sys_rst=0 (pipeline empty), but discard any in_stb presented while sys_rst=0.
REQ-029 SHALL drop all in-flight macropixels on a reset mid-operation, and produce no partial output after reset release.

Structure
REQ-030 SHALL place the coefficients (298, 409, 100, 208, 516), the offsets (16, 128), the rounding constant 128 and the intermediate width in the shared bt656cap package.
REQ-031 SHALL use one sub-module, bt656cap_ycc2rgb_pix (one pixel's S2/S3 math plus clamp), instantiated twice and sharing D and E.

Verification
REQ-032 SHALL cover black: in_ycc=0x80108010, out_ack=1 -> out_rgb565=0x00000000, exactly 3 cycles later.
REQ-033 SHALL cover white and red: Y=235, Cb=Cr=128 -> 0xFFFFFFFF; Y=81, Cb=90, Cr=240 -> 0xF800F800.
REQ-034 SHALL cover clamp: in_ycc=0xFFFFFFFF -> 0xFBFFFBFF; Y=0, Cb=Cr=128 -> 0x0000 per pixel (negative clamp).
REQ-035 SHALL cover backpressure: 8 back-to-back words with out_ack held 0 for 5 cycles -> in_ack=0 after 3 accepts; all 8 outputs emerged in order, unchanged, with field bits matching.
REQ-036 SHALL cover reset mid-stream: sys_rst=0 for one cycle with 3 words in flight -> out_stb=0 the next cycle and none of those 3 words ever emitted.
REQ-037 SHALL cover pix0_high=0: Y0=235, Y1=16, Cb=Cr=128 -> out_rgb565=0x0000FFFF.
